// File: rtl/ysyx_24080006_pkg.sv
// Shared definitions for the ysyx_24080006 core: fetch FSM states, reset PC,
// and system instruction encodings that decode matches on.
package ysyx_24080006_pkg;

  typedef enum logic [1:0] {
    REQ      = 2'd0,
    WAIT_RSP = 2'd1,
    HOLD     = 2'd2,
    WAIT_WB  = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // Instructions are word aligned; the low two bits of a redirect are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_24080006_ifu.sv
// Instruction fetch unit. Issues one read per instruction, hands {inst, pc}
// to decode over valid/ready, then waits for writeback to supply the next PC.
// The idu_* group is the producer side of the fetch-to-decode link (the
// "next" end of the core's uif bundle); it is kept flat here so the unit can
// be wired directly by the core or a bench.
module ysyx_24080006_ifu
  import ysyx_24080006_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          XLEN     = 32
) (
  input  logic            clock,
  input  logic            reset,
  // instruction memory
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  // decode
  output logic            idu_valid,
  input  logic            idu_ready,
  output logic [XLEN-1:0] idu_inst,
  output logic [XLEN-1:0] idu_pc,
  // writeback
  input  logic            wbu_valid,
  input  logic [XLEN-1:0] wbu_dnpc,
  // status
  output logic            fetch_err,
  output logic [XLEN-1:0] fetch_cnt
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mem_req_valid_q, mem_req_valid_d;
  logic            idu_valid_q, idu_valid_d;
  logic [XLEN-1:0] idu_inst_q, idu_inst_d;
  logic [XLEN-1:0] idu_pc_q, idu_pc_d;
  logic            fetch_err_q, fetch_err_d;
  logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;

  // State register; reset abandons any request in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= REQ;
      pc_q            <= RESET_PC;
      mem_req_valid_q <= 1'b0;
      idu_valid_q     <= 1'b0;
      idu_inst_q      <= '0;
      idu_pc_q        <= '0;
      fetch_err_q     <= 1'b0;
      fetch_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      mem_req_valid_q <= mem_req_valid_d;
      idu_valid_q     <= idu_valid_d;
      idu_inst_q      <= idu_inst_d;
      idu_pc_q        <= idu_pc_d;
      fetch_err_q     <= fetch_err_d;
      fetch_cnt_q     <= fetch_cnt_d;
    end
  end

  // Next-state and registered-output logic. A response is only looked at in
  // WAIT_RSP, so a late response from an aborted request falls on the floor.
  // wbu_valid is only honoured in WAIT_WB.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    idu_valid_d = idu_valid_q;
    idu_inst_d  = idu_inst_q;
    idu_pc_d    = idu_pc_q;
    fetch_err_d = 1'b0;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      REQ: begin
        if (mem_req_valid_q && mem_req_ready) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          if (mem_rsp_err) begin
            // drop the data and retry the same pc
            fetch_err_d = 1'b1;
            state_d     = REQ;
          end else begin
            idu_inst_d  = mem_rsp_data;
            idu_pc_d    = pc_q;
            idu_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (idu_valid_q && idu_ready) begin
          idu_valid_d = 1'b0;
          fetch_cnt_d = fetch_cnt_q + 1'b1;
          state_d     = WAIT_WB;
        end
      end
      WAIT_WB: begin
        if (wbu_valid) begin
          // misaligned redirect is flagged but still fetched, truncated
          pc_d        = align_pc(wbu_dnpc);
          fetch_err_d = |wbu_dnpc[1:0];
          state_d     = REQ;
        end
      end
      default: state_d = REQ;
    endcase

    // request is registered: it is up for exactly the cycles spent in REQ,
    // except the first cycle out of reset
    mem_req_valid_d = (state_d == REQ);
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = pc_q;
  assign idu_valid     = idu_valid_q;
  assign idu_inst      = idu_inst_q;
  assign idu_pc        = idu_pc_q;
  assign fetch_err     = fetch_err_q;
  assign fetch_cnt     = fetch_cnt_q;

endmodule

// File: tb/tb_ysyx_24080006_ifu.sv
// Self-checking bench for the fetch unit. Good responses push {inst, pc} to a
// scoreboard; each handoff to decode pops and compares it.
module tb_ysyx_24080006_ifu;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;
  logic        idu_valid, idu_ready;
  logic [31:0] idu_inst, idu_pc;
  logic        wbu_valid;
  logic [31:0] wbu_dnpc;
  logic        fetch_err;
  logic [31:0] fetch_cnt;

  int          total = 0;
  int          bad = 0;
  logic [63:0] sb_q[$];
  logic [31:0] exp_cnt;
  bit          in_wait_wb = 1'b0;
  int          illegal_wb = 0;

  ysyx_24080006_ifu #(.RESET_PC(RPC), .XLEN(32)) dut (
    .clock(clock), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .idu_valid(idu_valid), .idu_ready(idu_ready), .idu_inst(idu_inst), .idu_pc(idu_pc),
    .wbu_valid(wbu_valid), .wbu_dnpc(wbu_dnpc),
    .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
  );

  always #5 clock = ~clock;

  // flags a commit pulse arriving while the IFU is not waiting for one
  always @(posedge clock) begin
    if (reset === 1'b0 && wbu_valid === 1'b1 && !in_wait_wb) begin
      illegal_wb++;
      $display("note: wbu_valid outside WAIT_WB at %0t", $time);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, want test done");
    $fatal(1);
  end

  task automatic do_reset();
    reset = 1'b1;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rsp_data = '0;
    idu_ready = 1'b1; wbu_valid = 1'b0; wbu_dnpc = '0;
    @(negedge clock); @(negedge clock);
    sb_q.delete(); exp_cnt = '0; in_wait_wb = 1'b0;
  endtask

  // waits (bounded) for a request, checks its address, answers one cycle later
  task automatic issue(input logic [31:0] exp_pc, input logic [31:0] inst, input bit err);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (mem_req_valid === 1'b1) seen = 1'b1;
      else @(negedge clock);
    end
    total++;
    if (!seen) begin bad++; $display("FAIL req_timeout: got no mem_req_valid, want one"); return; end
    total++;
    if (mem_addr !== exp_pc) begin bad++; $display("FAIL req_addr: got %h want %h", mem_addr, exp_pc); end
    @(negedge clock);
    mem_rsp_valid = 1'b1; mem_rsp_data = inst; mem_rsp_err = err;
    if (!err) sb_q.push_back({inst, exp_pc});
    @(negedge clock);
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
  endtask

  // called on the cycle idu_valid should first be seen; stalls decode for hold cycles
  task automatic drain(input int hold);
    logic [63:0] exp = '0;
    total++;
    if (idu_valid !== 1'b1) begin bad++; $display("FAIL idu_valid_rise: got %b want 1", idu_valid); end
    total++;
    if (sb_q.size() == 0) begin bad++; $display("FAIL scoreboard: got empty want entry"); end
    else exp = sb_q.pop_front();
    total++;
    if ({idu_inst, idu_pc} !== exp) begin
      bad++; $display("FAIL idu_data: got %h/%h want %h/%h", idu_inst, idu_pc, exp[63:32], exp[31:0]);
    end
    if (hold > 0) begin
      idu_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        total++;
        if ({idu_valid, idu_inst, idu_pc} !== {1'b1, exp}) begin
          bad++; $display("FAIL hold_stable: got %b %h/%h want 1 %h/%h", idu_valid, idu_inst, idu_pc, exp[63:32], exp[31:0]);
        end
      end
      idu_ready = 1'b1;
    end
    @(negedge clock);
    exp_cnt++; in_wait_wb = 1'b1;
    total++;
    if (idu_valid !== 1'b0) begin bad++; $display("FAIL idu_valid_drop: got %b want 0", idu_valid); end
    total++;
    if (fetch_cnt !== exp_cnt) begin bad++; $display("FAIL fetch_cnt: got %0d want %0d", fetch_cnt, exp_cnt); end
  endtask

  // one-cycle commit pulse; on return the new request should be up
  task automatic wb(input logic [31:0] dnpc);
    bit          exp_err = |dnpc[1:0];
    logic [31:0] exp_pc  = {dnpc[31:2], 2'b00};
    wbu_valid = 1'b1; wbu_dnpc = dnpc;
    @(negedge clock);
    wbu_valid = 1'b0; in_wait_wb = 1'b0;
    total++;
    if (fetch_err !== exp_err) begin bad++; $display("FAIL wb_err: got %b want %b", fetch_err, exp_err); end
    total++;
    if (mem_req_valid !== 1'b1 || mem_addr !== exp_pc) begin
      bad++; $display("FAIL redirect: got %b/%h want 1/%h", mem_req_valid, mem_addr, exp_pc);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mem_req_valid, idu_valid, fetch_err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b want 000", {mem_req_valid, idu_valid, fetch_err});
    end
    total++;
    if ({idu_inst, idu_pc, fetch_cnt} !== 96'h0) begin
      bad++; $display("FAIL reset_regs: got %h/%h/%h want 0", idu_inst, idu_pc, fetch_cnt);
    end
    total++;
    if (mem_addr !== RPC) begin bad++; $display("FAIL reset_pc: got %h want %h", mem_addr, RPC); end
  endtask

  task automatic test_first_fetch();
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (mem_req_valid !== 1'b1) begin bad++; $display("FAIL first_req: got %b want 1", mem_req_valid); end
    issue(RPC, 32'h0010_0093, 1'b0);
    drain(0);
  endtask

  task automatic test_hold();
    wb(32'h8000_0004);
    issue(32'h8000_0004, 32'h0020_0113, 1'b0);
    drain(5);
    @(negedge clock); @(negedge clock);
    total++;
    if (fetch_cnt !== exp_cnt || idu_valid !== 1'b0) begin
      bad++; $display("FAIL single_transfer: got cnt %0d valid %b want %0d 0", fetch_cnt, idu_valid, exp_cnt);
    end
  endtask

  task automatic test_redirect();
    int n0;
    wb(32'h8000_0010);
    issue(32'h8000_0010, 32'h0030_0193, 1'b0);
    n0 = illegal_wb;
    idu_ready = 1'b0; wbu_valid = 1'b1; wbu_dnpc = 32'h1234_5678;
    @(negedge clock);
    wbu_valid = 1'b0;
    total++;
    if (illegal_wb !== n0 + 1) begin bad++; $display("FAIL wb_in_hold_flag: got %0d want %0d", illegal_wb, n0 + 1); end
    total++;
    if (mem_addr !== 32'h8000_0010 || fetch_err !== 1'b0) begin
      bad++; $display("FAIL wb_in_hold_ignored: got %h/%b want 80000010/0", mem_addr, fetch_err);
    end
    drain(1);
    total++;
    if (mem_addr !== 32'h8000_0010) begin bad++; $display("FAIL pc_kept: got %h want 80000010", mem_addr); end
  endtask

  task automatic test_misaligned();
    wb(32'h8000_0006);
    mem_req_ready = 1'b0;
    @(negedge clock);
    total++;
    if (fetch_err !== 1'b0 || mem_addr !== 32'h8000_0004) begin
      bad++; $display("FAIL misalign_pulse: got %b/%h want 0/80000004", fetch_err, mem_addr);
    end
    mem_req_ready = 1'b1;
    issue(32'h8000_0004, 32'h0040_0213, 1'b0);
    drain(0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc = 32'h8000_0004;
    for (int k = 0; k < 4; k++) begin
      pc = pc + 32'd4;
      wb(pc);
      issue(pc, $urandom, 1'b0);
      drain(0);
    end
  endtask

  task automatic test_bus_err();
    do_reset();
    reset = 1'b0;
    issue(RPC, 32'hbad0_bad0, 1'b1);
    total++;
    if (fetch_err !== 1'b1 || idu_valid !== 1'b0) begin
      bad++; $display("FAIL err_pulse: got err %b valid %b want 1 0", fetch_err, idu_valid);
    end
    total++;
    if (mem_req_valid !== 1'b1 || mem_addr !== RPC) begin
      bad++; $display("FAIL err_retry: got %b/%h want 1/%h", mem_req_valid, mem_addr, RPC);
    end
    mem_req_ready = 1'b0;
    @(negedge clock);
    total++;
    if (fetch_err !== 1'b0 || idu_valid !== 1'b0) begin
      bad++; $display("FAIL err_width: got err %b valid %b want 0 0", fetch_err, idu_valid);
    end
    mem_req_ready = 1'b1;
    issue(RPC, 32'h00a0_0513, 1'b0);
    drain(0);
  endtask

  task automatic test_reset_abort();
    wb(32'h8000_0020);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    sb_q.delete(); exp_cnt = '0; in_wait_wb = 1'b0;
    total++;
    if (idu_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_addr !== RPC || fetch_cnt !== 32'd0) begin
      bad++; $display("FAIL abort_reset: got %b %b %h %0d want 0 0 %h 0", idu_valid, mem_req_valid, mem_addr, fetch_cnt, RPC);
    end
    reset = 1'b0; mem_req_ready = 1'b0;
    @(negedge clock);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hdead_beef;
    @(negedge clock);
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (idu_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_addr !== RPC) begin
        bad++; $display("FAIL stale_rsp: got %b %b %h want 0 1 %h", idu_valid, mem_req_valid, mem_addr, RPC);
      end
      @(negedge clock);
    end
    mem_req_ready = 1'b1;
    issue(RPC, 32'h0000_0073, 1'b0);
    drain(0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_hold();
    test_redirect();
    test_misaligned();
    test_back_to_back();
    test_bus_err();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
